// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the registered ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND      = 4'b0000;
    localparam logic [3:0] OP_OR       = 4'b0001;
    localparam logic [3:0] OP_ADD      = 4'b0010;
    localparam logic [3:0] OP_MUL      = 4'b0011;
    localparam logic [3:0] OP_SUB      = 4'b0110;
    localparam logic [3:0] OP_LESSTHAN = 4'b0111;
    localparam logic [3:0] OP_SRL      = 4'b1000;
    localparam logic [3:0] OP_SLL      = 4'b1001;
    localparam logic [3:0] OP_SRA      = 4'b1010;
    localparam logic [3:0] OP_XOR      = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath for every opcode except the iterative multiply.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;

    assign sum   = {1'b0, op1} + {1'b0, op2};
    // Top bit of the zero-extended difference is the unsigned borrow.
    assign diff  = {1'b0, op1} - {1'b0, op2};
    assign shamt = op2[SHW-1:0];

    always_comb begin
        result  = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            OP_AND: result = op1 & op2;
            OP_OR:  result = op1 | op2;
            OP_XOR: result = op1 ^ op2;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_MUL:      result = '0;
            OP_LESSTHAN: result = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SRL:      result = op1 >> shamt;
            OP_SLL:      result = op1 << shamt;
            OP_SRA:      result = $unsigned($signed(op1) >>> shamt);
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a shift-add multiplier.
//   state   | meaning
//   IDLE    | waiting for an operation, in_ready=1
//   MUL     | shift-add iterations in progress, in_ready=0
//   DONE    | result/flags valid, held until out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 illegal_q, illegal_d;

    logic [WIDTH-1:0]     comb_result;
    logic                 comb_carry;
    logic                 comb_ovf;
    logic                 comb_illegal;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 ready_c;
    logic                 accept;

    alu_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .op1     (op1),
        .op2     (op2),
        .alu_op  (alu_op),
        .result  (comb_result),
        .carry   (comb_carry),
        .ovf     (comb_ovf),
        .illegal (comb_illegal)
    );

    assign ready_c = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept  = in_valid && ready_c;
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d  = acc_sum[WIDTH-1:0];
                    zero_d    = (acc_sum[WIDTH-1:0] == '0);
                    neg_d     = acc_sum[WIDTH-1];
                    carry_d   = 1'b0;
                    ovf_d     = |acc_sum[2*WIDTH-1:WIDTH];
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready && !in_valid) state_d = ST_IDLE;
            end
            default: ;
        endcase

        // A new operation (from IDLE or back-to-back from DONE) overrides the above.
        if (accept) begin
            if (alu_op == OP_MUL) begin
                mcand_d  = {{WIDTH{1'b0}}, op1};
                mplier_d = op2;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_MUL;
            end else begin
                result_d  = comb_result;
                zero_d    = (comb_result == '0);
                neg_d     = comb_result[WIDTH-1];
                carry_d   = comb_carry;
                ovf_d     = comb_ovf;
                illegal_d = comb_illegal;
                state_d   = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = ready_c;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [3:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
    logic         illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // flag order: {out_valid, zero, neg, carry, ovf, illegal}
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        op1      = a;
        op2      = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; alu_op = 4'b0000;
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_hs: got %b, want 10", {in_ready, out_valid});
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result: got %h, want 00000000", result);
        end
        n_checks++;
        if ({zero, neg, carry, ovf, illegal} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flags: got %b, want 00000", {zero, neg, carry, ovf, illegal});
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        n_checks++;
        if ({out_valid, result, zero, neg, carry, ovf, illegal} !== {1'b1, 32'h8000_0000, 5'b01010}) begin
            n_fail++; $display("FAIL add_ovf: got v=%b r=%h f=%b, want v=1 r=80000000 f=01010",
                               out_valid, result, {zero, neg, carry, ovf, illegal});
        end
        step();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL add_release: got %b, want 01", {out_valid, in_ready});
        end
        drive_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        n_checks++;
        if ({out_valid, result, zero, neg, carry, ovf, illegal} !== {1'b1, 32'h0, 5'b10100}) begin
            n_fail++; $display("FAIL add_carry: got v=%b r=%h f=%b, want v=1 r=00000000 f=10100",
                               out_valid, result, {zero, neg, carry, ovf, illegal});
        end
        step();
    endtask

    task automatic test_sub_lt();
        out_ready = 1'b1;
        drive_op(4'b0110, 32'd5, 32'd7);
        n_checks++;
        if ({out_valid, result, zero, neg, carry, ovf, illegal} !== {1'b1, 32'hFFFF_FFFE, 5'b01100}) begin
            n_fail++; $display("FAIL sub_borrow: got v=%b r=%h f=%b, want v=1 r=fffffffe f=01100",
                               out_valid, result, {zero, neg, carry, ovf, illegal});
        end
        step();
        drive_op(4'b0111, 32'hFFFF_FFFE, 32'd3);
        n_checks++;
        if ({out_valid, result, zero, neg, carry, ovf, illegal} !== {1'b1, 32'h1, 5'b00000}) begin
            n_fail++; $display("FAIL lessthan: got v=%b r=%h f=%b, want v=1 r=00000001 f=00000",
                               out_valid, result, {zero, neg, carry, ovf, illegal});
        end
        step();
    endtask

    task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_r, input logic [4:0] exp_f);
        int  lat;
        bit  busy_ok;
        out_ready = 1'b1;
        drive_op(4'b0011, a, b);
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            step();
            lat++;
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL %s_latency: got %0d, want 33", name, lat);
        end
        n_checks++;
        if (busy_ok !== 1'b1) begin
            n_fail++; $display("FAIL %s_busy: in_ready rose during MUL, want 0", name);
        end
        n_checks++;
        if ({out_valid, result, zero, neg, carry, ovf, illegal} !== {1'b1, exp_r, exp_f}) begin
            n_fail++; $display("FAIL %s_result: got v=%b r=%h f=%b, want v=1 r=%h f=%b",
                               name, out_valid, result, {zero, neg, carry, ovf, illegal}, exp_r, exp_f);
        end
        step();
    endtask

    task automatic test_mul();
        run_mul("mul_big", 32'h0001_0000, 32'h0001_0000, 32'h0, 5'b10010);
        run_mul("mul_small", 32'd1234, 32'd5678, 32'd7006652, 5'b00000);
    endtask

    task automatic test_back_to_back();
        bit held_ok;
        out_ready = 1'b0;
        drive_op(4'b1010, 32'h8000_0000, 32'd4);
        in_valid = 1'b1; alu_op = 4'b1101; op1 = 32'hF0F0_F0F0; op2 = 32'hFF00_FF00;
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ({out_valid, in_ready, result} !== {2'b10, 32'hF800_0000}) held_ok = 1'b0;
            step();
        end
        n_checks++;
        if (held_ok !== 1'b1 || result !== 32'hF800_0000) begin
            n_fail++; $display("FAIL sra_hold: got r=%h v=%b rdy=%b, want r=f8000000 v=1 rdy=0",
                               result, out_valid, in_ready);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b, want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result, zero, neg} !== {1'b1, 32'h0FF0_0FF0, 2'b00}) begin
            n_fail++; $display("FAIL b2b_xor: got v=%b r=%h, want v=1 r=0ff00ff0", out_valid, result);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got out_valid=%b, want 0", out_valid);
        end
        drive_op(4'b1000, 32'h8000_0000, 32'd4);
        n_checks++;
        if ({result, neg} !== {32'h0800_0000, 1'b0}) begin
            n_fail++; $display("FAIL srl: got %h, want 08000000", result);
        end
        step();
    endtask

    task automatic test_illegal_shift();
        out_ready = 1'b1;
        drive_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        n_checks++;
        if ({out_valid, result, zero, neg, carry, ovf, illegal} !== {1'b1, 32'h0, 5'b10001}) begin
            n_fail++; $display("FAIL illegal_op: got v=%b r=%h f=%b, want v=1 r=00000000 f=10001",
                               out_valid, result, {zero, neg, carry, ovf, illegal});
        end
        step();
        drive_op(4'b1001, 32'd1, 32'h0000_0021);
        n_checks++;
        if ({result, zero, illegal} !== {32'h2, 2'b00}) begin
            n_fail++; $display("FAIL sll_mask: got r=%h z=%b il=%b, want r=00000002 z=0 il=0",
                               result, zero, illegal);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        bit stale;
        out_ready = 1'b1;
        drive_op(4'b0011, 32'd1234, 32'd5678);
        repeat (9) step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, result, zero, neg, carry, ovf, illegal} !== {2'b10, 32'h0, 5'b00000}) begin
            n_fail++; $display("FAIL async_reset: got rdy=%b v=%b r=%h f=%b, want rdy=1 v=0 r=00000000 f=00000",
                               in_ready, out_valid, result, {zero, neg, carry, ovf, illegal});
        end
        #10 rst = 1'b0;
        step();
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
            step();
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++; $display("FAIL reset_stale: out_valid or in_ready wrong after aborted MUL");
        end
        drive_op(4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F);
        n_checks++;
        if ({out_valid, result, zero, neg, carry, ovf, illegal} !== {1'b1, 32'h0F00_0F00, 5'b00000}) begin
            n_fail++; $display("FAIL and_after_reset: got v=%b r=%h, want v=1 r=0f000f00", out_valid, result);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_lt();
        test_mul();
        test_back_to_back();
        test_illegal_shift();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational 32-bit ALU.
- Same opcode set, plus an iterative shift-add unsigned multiply.
- Adds a valid/ready handshake on input and output, and registered status flags (zero, negative, carry, overflow, illegal-op).
- Sits between the calculator FSM and the result/display register. One operation in flight at a time.

Parameters:
- WIDTH, 32: operand and result width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width; op2[SHW-1:0] is used for shifts.
- Opcode localparams (4 bits): AND=0000, OR=0001, ADD=0010, MUL=0011, SUB=0110, LESSTHAN=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  op1/op2/alu_op are valid.
- in_ready  out  1  block can accept an operation this cycle.
- op1  in  WIDTH  first operand, two's complement.
- op2  in  WIDTH  second operand, two's complement.
- alu_op  in  4  operation code.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- carry  out  1  ADD: carry-out. SUB: borrow (op1 < op2 unsigned). Otherwise 0.
- ovf  out  1  ADD/SUB: signed overflow. MUL: unsigned high half nonzero. Otherwise 0.
- illegal  out  1  alu_op is not in the opcode list.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, and zero, neg, carry, ovf, illegal all 0.
- Reset asserted mid-operation aborts it. The partial product is discarded and no out_valid is produced.
- States are IDLE, MUL, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- An operation is accepted when in_valid && in_ready; operands and opcode are captured on acceptance.
- Non-MUL operation accepted (including illegal opcodes): compute combinationally from the captured inputs and register result and flags at that edge. Next state is DONE. out_valid is high in the following cycle (latency 1).
- MUL operation accepted:
  - Load the multiplicand, the multiplier and a 2*WIDTH-bit accumulator (0), and clear the counter. Next state is MUL.
  - In MUL, each cycle: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator. Shift the multiplicand left and the multiplier right, and increment the counter.
  - After WIDTH iterations, register result = accumulator[WIDTH-1:0] and ovf = |accumulator[2W-1:W]. Next state is DONE.
  - Latency is WIDTH+1 cycles from acceptance to out_valid. in_ready=0 throughout MUL.
- DONE: out_valid=1. result and flags are held stable until out_ready.
  - out_ready && !in_valid: next state IDLE, out_valid drops.
  - out_ready && in_valid: back-to-back. The new operation is accepted in the same cycle, and the next state follows the rules for the new opcode.
- Operation semantics:
  - Arithmetic wraps modulo 2^WIDTH.
  - LESSTHAN is a signed comparison; result is 1 or 0, zero-extended.
  - SRA is a sign-propagating shift. SRL and SLL shift in zeros. Shift amount is op2[SHW-1:0].
  - Illegal opcode: result=0, illegal=1, zero=1.
- Flags: zero and neg are computed from the final registered result for every operation. carry and ovf follow the Ports definitions.
- in_valid is ignored in MUL state, and in DONE when out_ready=0. No operation is queued.

Decomposition:
- Package alu_pkg: the opcode localparams and a state enum/localparams (IDLE, MUL, DONE).
- Sub-module alu_comb: the parametrised single-cycle datapath, with inputs op1, op2, alu_op and outputs result, carry, ovf, illegal.
- alu_seq contains the FSM, the multiply iterator and the output registers.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF + 1, out_ready=1 -> 1 cycle later out_valid=1, result=0x80000000, ovf=1, neg=1, carry=0.
- SUB 5 - 7 -> result=0xFFFFFFFE, carry=1 (borrow), ovf=0, neg=1. Then LESSTHAN −2 vs 3 -> result=1.
- MUL 0x00010000 * 0x00010000 -> out_valid exactly 33 cycles after acceptance, result=0, ovf=1, zero=1, in_ready=0 throughout. Repeat with 1234 * 5678 -> result=7006652, ovf=0.
- Hold out_ready=0 for 5 cycles after SRA 0x80000000 by 4 -> result stays 0xF8000000 and in_ready=0. Then assert out_ready with in_valid (XOR) -> back-to-back accept in the same cycle.
- Illegal opcode 4'b1111 -> result=0, illegal=1, zero=1. SLL 1 by op2=0x21 -> result=2 (amount masked to 5 bits).
- Assert rst at iteration 10 of a MUL -> outputs return to reset values immediately (async). After release, in_ready=1 and no stale out_valid. A new AND completes normally.
